// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter in front of the memory controller's c_* port.
//   Port 0 is instruction fetch (read only), port 1 is data load/store.
//   One port is granted at a time. Its address, length, write data and
//   operation are latched. The controller level handshake is then run
//   (req high -> ack high -> req low -> ack low). After that, the read data
//   and a done ack go back to the granted port. The ack stays high until that
//   port drops its request.
//
//   Configuration macro: MARB_RR_EN
//     defined   - round-robin. The pointer toggles after every completed grant.
//     undefined - fixed priority. Port FIXED_HI wins ties.
//
// Ports
//   clk, rst              clock (posedge); async active-low reset
//   p0_re/addr/len        port0 read request (held until p0_ack), address, length
//   p0_rdata, p0_ack      port0 read data and done
//   p1_re/we/addr/len     port1 read/write request, address, length
//   p1_wdata              port1 write data
//   p1_rdata, p1_ack      port1 read data and done
//   c_re/c_we             read/write request to the controller
//   c_raddr/c_rlen        read address and length
//   c_waddr/c_wlen/c_din  write address, length and data
//   c_dout/c_rack/c_wack  read data, read ack and write ack from the controller
//   gnt                   one-hot current grant, 00 when idle
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 2,
    parameter int FIXED_HI = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_re,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [LEN_W-1:0]  p0_len,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    input  logic              p1_re,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [LEN_W-1:0]  p1_len,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              c_re,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_raddr,
    output logic [ADDR_W-1:0] c_waddr,
    output logic [LEN_W-1:0]  c_rlen,
    output logic [LEN_W-1:0]  c_wlen,
    output logic [DATA_W-1:0] c_din,
    input  logic [DATA_W-1:0] c_dout,
    input  logic              c_rack,
    input  logic              c_wack,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, DROP, RESP} state_t;

    state_t state;
    logic   sel;      // granted port: 0 or 1
    logic   op_we;    // latched operation: 1 = write
    logic   req0;
    logic   req1;
    logic   hi_port;  // port that wins a tie
    logic   pick1;
    logic   op_ack;   // only the ack that matches the latched op counts
    logic   sel_idle; // granted port has dropped all of its requests

`ifdef MARB_RR_EN
    logic ptr;
    assign hi_port = ptr;
`else
    assign hi_port = (FIXED_HI != 0);
`endif

    assign req0     = p0_re;
    assign req1     = p1_re | p1_we;
    assign pick1    = req1 & (~req0 | hi_port);
    assign op_ack   = op_we ? c_wack : c_rack;
    assign sel_idle = sel ? ~(p1_re | p1_we) : ~p0_re;

    // Grant FSM. Every output is a register, so the controller sees clean
    // levels. The address, length and data are latched at grant time. The
    // request rises one cycle later, which keeps those values stable for a
    // full cycle before the request goes high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            op_we    <= 1'b0;
            gnt      <= 2'b00;
            c_re     <= 1'b0;
            c_we     <= 1'b0;
            c_raddr  <= '0;
            c_waddr  <= '0;
            c_rlen   <= '0;
            c_wlen   <= '0;
            c_din    <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
`ifdef MARB_RR_EN
            ptr      <= (FIXED_HI != 0);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        sel   <= pick1;
                        gnt   <= pick1 ? 2'b10 : 2'b01;
                        // A port1 read+write collapses to the write
                        op_we <= pick1 & p1_we;
                        if (pick1 & p1_we) begin
                            c_waddr <= p1_addr;
                            c_wlen  <= p1_len;
                            c_din   <= p1_wdata;
                        end else begin
                            c_raddr <= pick1 ? p1_addr : p0_addr;
                            c_rlen  <= pick1 ? p1_len  : p0_len;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!c_re && !c_we) begin
                        c_re <= ~op_we;
                        c_we <= op_we;
                    end else if (op_ack) begin
                        if (!op_we) begin
                            if (sel) p1_rdata <= c_dout;
                            else     p0_rdata <= c_dout;
                        end
                        c_re  <= 1'b0;
                        c_we  <= 1'b0;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (!op_ack) begin
                        if (sel) p1_ack <= 1'b1;
                        else     p0_ack <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (sel_idle) begin
                        p0_ack <= 1'b0;
                        p1_ack <= 1'b0;
                        gnt    <= 2'b00;
                        state  <= IDLE;
`ifdef MARB_RR_EN
                        ptr    <= ~ptr;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. The bench models a memory that acks as
//   soon as a request is seen, and it can be stalled. Each expected completion
//   (grant plus read data) is queued when a request is driven. The entry is
//   popped and compared when a port ack rises.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_re;
    logic [31:0] p0_addr;
    logic [1:0]  p0_len;
    logic [31:0] p0_rdata;
    logic        p0_ack;
    logic        p1_re;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [1:0]  p1_len;
    logic [31:0] p1_wdata;
    logic [31:0] p1_rdata;
    logic        p1_ack;
    logic        c_re;
    logic        c_we;
    logic [31:0] c_raddr;
    logic [31:0] c_waddr;
    logic [1:0]  c_rlen;
    logic [1:0]  c_wlen;
    logic [31:0] c_din;
    logic [31:0] c_dout;
    logic        c_rack;
    logic        c_wack;
    logic [1:0]  gnt;

    logic        mem_stall;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  gnt;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    // Values seen on the controller port when the current request rose
    logic        was_active = 1'b0;
    logic        seen_re, seen_we;
    logic [31:0] seen_addr, seen_din;
    logic [1:0]  seen_len;
    int          issue_count = 0;
    logic        prev0 = 1'b0, prev1 = 1'b0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_re(p0_re), .p0_addr(p0_addr), .p0_len(p0_len),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_re(p1_re), .p1_we(p1_we), .p1_addr(p1_addr), .p1_len(p1_len),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .c_re(c_re), .c_we(c_we), .c_raddr(c_raddr), .c_waddr(c_waddr),
        .c_rlen(c_rlen), .c_wlen(c_wlen), .c_din(c_din), .c_dout(c_dout),
        .c_rack(c_rack), .c_wack(c_wack), .gnt(gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait memory. A stall holds the ack low.
    assign c_rack = c_re & ~mem_stall;
    assign c_wack = c_we & ~mem_stall;
    assign c_dout = mem_data;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic re0, input logic [31:0] a0, input logic [1:0] l0,
                                 input logic re1, input logic we1, input logic [31:0] a1,
                                 input logic [1:0] l1, input logic [31:0] wd1);
        p0_re = re0; p0_addr = a0; p0_len = l0;
        p1_re = re1; p1_we = we1; p1_addr = a1; p1_len = l1; p1_wdata = wd1;
    endtask

    task automatic waitAck(input string tag, input int port, input logic level,
                           input int max, output int cycles);
        bit ok;
        ok = 0;
        cycles = 0;
        while (cycles < max && !ok) begin
            @(negedge clk);
            cycles++;
            if (((port == 0) ? p0_ack : p1_ack) == level) ok = 1;
        end
        checkOutput({tag, "_timeout"}, 64'(ok), 64'(1));
    endtask

    // Controller-side monitor. It records each request and checks that the
    // request and its qualifiers stay stable. It also pops the scoreboard
    // whenever a port ack rises.
    always @(negedge clk) begin
        if (!rst) begin
            was_active = 1'b0;
            prev0 = 1'b0;
            prev1 = 1'b0;
        end else begin
            if ((c_re | c_we) && !was_active) begin
                seen_re   = c_re;
                seen_we   = c_we;
                seen_addr = c_we ? c_waddr : c_raddr;
                seen_len  = c_we ? c_wlen : c_rlen;
                seen_din  = c_din;
                issue_count++;
            end else if (c_re | c_we) begin
                checkOutput("c_stable", 64'({c_re, c_we, (c_we ? c_wlen : c_rlen), (c_we ? c_waddr : c_raddr)}),
                            64'({seen_re, seen_we, seen_len, seen_addr}));
            end
            was_active = c_re | c_we;
            if ((p0_ack && !prev0) || (p1_ack && !prev1)) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_ack", 64'({p1_ack, p0_ack}), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("sb_gnt", 64'(gnt), 64'(e.gnt));
                    checkOutput("sb_ack_port", 64'({p1_ack, p0_ack}), 64'(e.gnt));
                    if (e.chk_data)
                        checkOutput("sb_rdata", 64'(e.gnt[1] ? p1_rdata : p0_rdata), 64'(e.data));
                end
            end
            prev0 = p0_ack;
            prev1 = p1_ack;
        end
    end

    initial begin
        int cyc;
        int model_ptr;
        int issue_before;
        exp_t e;

        rst = 1'b0;
        mem_stall = 1'b0;
        mem_data = '0;
        model_ptr = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        checkOutput("rst_ctrl", 64'({c_re, c_we, gnt, p0_ack, p1_ack}), 64'(0));
        checkOutput("rst_rdata", 64'({p0_rdata, p1_rdata}), 64'(0));
        checkOutput("rst_addr", 64'({c_raddr, c_waddr}), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // p0 read of 0x1000, four bytes
        $display("[TB] p0 read");
        mem_data = 32'hDEADBEEF;
        e = '{gnt: 2'b01, chk_data: 1'b1, data: 32'hDEADBEEF};
        sb.push_back(e);
        applyStimulus(1, 32'h0000_1000, 2'd3, 0, 0, 0, 0, 0);
        waitAck("p0_rd_ack", 0, 1'b1, 20, cyc);
        checkOutput("p0_rd_latency", 64'(cyc), 64'(4));
        checkOutput("p0_rd_addr", 64'(seen_addr), 64'h1000);
        checkOutput("p0_rd_len", 64'(seen_len), 64'(3));
        checkOutput("p0_rd_op", 64'({seen_re, seen_we}), 64'(2'b10));
        checkOutput("p0_rd_cre_low", 64'(c_re), 64'(0));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitAck("p0_rd_rel", 0, 1'b0, 10, cyc);
        checkOutput("p0_rd_gnt_idle", 64'(gnt), 64'(0));
        if (`ifdef MARB_RR_EN 1 `else 0 `endif) model_ptr ^= 1;

        // p1 write of 0xABCD to 0x20, two bytes
        $display("[TB] p1 write");
        e = '{gnt: 2'b10, chk_data: 1'b0, data: 32'h0};
        sb.push_back(e);
        applyStimulus(0, 0, 0, 0, 1, 32'h20, 2'd1, 32'h0000_ABCD);
        waitAck("p1_wr_ack", 1, 1'b1, 20, cyc);
        checkOutput("p1_wr_op", 64'({seen_re, seen_we}), 64'(2'b01));
        checkOutput("p1_wr_addr", 64'(seen_addr), 64'h20);
        checkOutput("p1_wr_len", 64'(seen_len), 64'(1));
        checkOutput("p1_wr_din", 64'(seen_din), 64'hABCD);
        checkOutput("p1_wr_cwe_low", 64'(c_we), 64'(0));
        checkOutput("p0_rdata_hold", 64'(p0_rdata), 64'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitAck("p1_wr_rel", 1, 1'b0, 10, cyc);
        if (`ifdef MARB_RR_EN 1 `else 0 `endif) model_ptr ^= 1;

        // Simultaneous reads; both ports keep requesting until they are served
        $display("[TB] tie, both held");
        mem_data = 32'h1111_1111;
        e = '{gnt: (model_ptr == 1) ? 2'b10 : 2'b01, chk_data: 1'b1, data: 32'h1111_1111};
        sb.push_back(e);
        e = '{gnt: (model_ptr == 1) ? 2'b01 : 2'b10, chk_data: 1'b1, data: 32'h2222_2222};
        sb.push_back(e);
        applyStimulus(1, 32'h100, 2'd0, 1, 0, 32'h200, 2'd0, 0);
        waitAck("tie_first", (model_ptr == 1) ? 1 : 0, 1'b1, 20, cyc);
        mem_data = 32'h2222_2222;
        if (model_ptr == 1) p1_re = 1'b0; else p0_re = 1'b0;
        waitAck("tie_second", (model_ptr == 1) ? 0 : 1, 1'b1, 20, cyc);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitAck("tie_rel", (model_ptr == 1) ? 0 : 1, 1'b0, 10, cyc);

        // Four ties. The loser withdraws once the winner is latched, so each
        // tie yields a single grant.
        $display("[TB] repeated ties");
        for (int i = 0; i < 4; i++) begin
            int win;
            win = model_ptr;
            mem_data = 32'hA000_0000 + i;
            e = '{gnt: (win == 1) ? 2'b10 : 2'b01, chk_data: 1'b1, data: 32'hA000_0000 + i};
            sb.push_back(e);
            applyStimulus(1, 32'h300 + i, 2'd1, 1, 0, 32'h400 + i, 2'd2, 0);
            @(negedge clk);
            if (win == 1) p0_re = 1'b0; else p1_re = 1'b0;
            waitAck("rr_ack", win, 1'b1, 20, cyc);
            checkOutput("rr_addr", 64'(seen_addr), 64'((win == 1) ? 32'h400 + i : 32'h300 + i));
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            waitAck("rr_rel", win, 1'b0, 10, cyc);
            if (`ifdef MARB_RR_EN 1 `else 0 `endif) model_ptr ^= 1;
        end

        // p1 address changes after it has been latched
        $display("[TB] p1 addr change during grant");
        mem_data = 32'h0BAD_F00D;
        e = '{gnt: 2'b10, chk_data: 1'b1, data: 32'h0BAD_F00D};
        sb.push_back(e);
        applyStimulus(0, 0, 0, 1, 0, 32'h40, 2'd2, 0);
        @(negedge clk);
        p1_addr = 32'h80;
        waitAck("p1_chg_ack", 1, 1'b1, 20, cyc);
        checkOutput("p1_chg_seen", 64'(seen_addr), 64'h40);
        checkOutput("p1_chg_craddr", 64'(c_raddr), 64'h40);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitAck("p1_chg_rel", 1, 1'b0, 10, cyc);

        // p1 read and write together: only the write goes out
        $display("[TB] p1 read+write");
        e = '{gnt: 2'b10, chk_data: 1'b0, data: 32'h0};
        sb.push_back(e);
        applyStimulus(0, 0, 0, 1, 1, 32'h60, 2'd3, 32'h1234);
        waitAck("p1_rw_ack", 1, 1'b1, 20, cyc);
        checkOutput("p1_rw_op", 64'({seen_re, seen_we}), 64'(2'b01));
        checkOutput("p1_rw_addr", 64'(seen_addr), 64'h60);
        checkOutput("p1_rw_din", 64'(seen_din), 64'h1234);
        checkOutput("p1_rw_rdata_hold", 64'(p1_rdata), 64'h0BAD_F00D);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitAck("p1_rw_rel", 1, 1'b0, 10, cyc);

        // Reset while a stalled read is being issued
        $display("[TB] reset mid-transfer");
        mem_stall = 1'b1;
        applyStimulus(1, 32'h500, 2'd0, 0, 0, 0, 0, 0);
        cyc = 0;
        while (cyc < 10 && !c_re) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("rst_mid_issue_seen", 64'(c_re), 64'(1));
        issue_before = issue_count;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rst_mid_ctrl", 64'({c_re, p0_ack, gnt}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        mem_stall = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rst_mid_no_issue", 64'(issue_count), 64'(issue_before));
        checkOutput("rst_mid_idle", 64'({c_re, c_we, gnt, p0_ack, p1_ack}), 64'(0));

        checkOutput("sb_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
